load_data_router: RTL and testbench
===================================

// Module: load_data_router
// PURPOSE
//  Streams fused DDR/DMA load words into on-chip buffers: one IFM BRAM, the L1_BANKS layer-1 weight banks
//  and the L2_BANKS layer-2 weight banks. Routing uses internal word counters striped round-robin across
//  banks, not an external address. Sits between the load DMA front-end and the BRAM_IFM/BRAM_Weight arrays.
//  Sequences IFM or weight-L1-then-L2 load phases under a start/done handshake.
// PARAMETERS
//  DATA_W    32  load word width (bank write-data width)
//  L1_BANKS  16  layer-1 weight banks; power of 2, >=2
//  L2_BANKS  4   layer-2 weight banks; power of 2, >=2
//  BANK_AW   16  per-bank word-address width
//  SIZE_W    32  width of size inputs (word counts)
// PORTS
//  clk           in   1                    clock
//  rst_n         in   1                    async active-low reset
//  start         in   1                    pulse; latches mode and sizes, begins load
//  control_load  in   2                    0 NO_LOAD, 1 LOAD_IFM, 2 LOAD_WEIGHT, 3 reserved
//  size_ifm      in   SIZE_W               IFM words to load
//  size_w_l1     in   SIZE_W               layer-1 weight words
//  size_w_l2     in   SIZE_W               layer-2 weight words
//  abort         in   1                    sync abort to IDLE
//  in_valid      in   1                    load word valid
//  in_ready      out  1                    router accepts word
//  in_data       in   DATA_W               load word
//  wr_data       out  DATA_W               registered data, broadcast to all banks
//  ifm_we        out  1                    IFM write enable
//  ifm_addr      out  SIZE_W               IFM word address
//  l1_we         out  L1_BANKS             one-hot layer-1 bank enable
//  l1_addr       out  BANK_AW              shared layer-1 bank address
//  l2_we         out  L2_BANKS             one-hot layer-2 bank enable
//  l2_addr       out  BANK_AW              shared layer-2 bank address
//  busy          out  1                    high from start accept until done
//  done          out  1                    one-cycle pulse at end of load
//  err_mode      out  1                    sticky; start with control_load 0 or 3; cleared by next valid start
// BEHAVIOUR
//  - Reset: all outputs 0; FSM IDLE; counters 0.
//  - FSM: IDLE -> (start & mode=1) LD_IFM | (start & mode=2) LD_W1 | (start & mode 0/3) IDLE + err_mode=1.
//    LD_W1 -> LD_W2 on last L1 word. LD_W2 -> FIN on last L2 word. LD_IFM -> FIN on last word.
//    FIN: done=1 for one cycle -> IDLE.
//  - Zero sizes: a phase with size 0 is skipped in the same transition. Weight load with both sizes 0,
//    or IFM load with size 0, goes straight to FIN (done 1 cycle after start).
//  - start is ignored while busy. Sizes are sampled only on accepted start.
//  - in_ready = 1 exactly in LD_IFM/LD_W1/LD_W2. A beat transfers when in_valid & in_ready. No BRAM backpressure.
//  - Latency: a beat accepted at cycle t gives registered we/addr/wr_data at t+1. Enables are 0 otherwise.
//  - Striping, k = phase word count: bank = k mod NBANKS (low log2 bits), bank addr = k >> log2(NBANKS),
//    truncated to BANK_AW. IFM addr = k.
//  - The last beat of a phase is accepted; the next cycle is the next phase or FIN, with no dead cycle.
//  - abort (priority over everything except reset): next state IDLE, counters cleared, we outputs 0
//    next cycle, done not pulsed. Any beat coincident with abort is dropped.
//  - Async reset mid-load: immediate return to reset state; partial bank contents undefined.
// CONFIGURATION
//  LOAD_ROUTER_CHECKSUM_EN defined: extra output checksum[DATA_W-1:0] = modulo-2^DATA_W sum of all words
//    accepted since the last accepted start. It is cleared on start/abort and valid while done=1.
//  Undefined: no checksum port or logic.
// STRUCTURE
//  load_router_pkg: load_mode_e {NO_LOAD=0, LOAD_IFM=1, LOAD_WEIGHT=2}, router_state_e
//    {IDLE, LD_IFM, LD_W1, LD_W2, FIN}.
//  Sub-module bank_stripe_gen #(NBANKS, BANK_AW, SIZE_W): a word counter that generates the one-hot we
//    and bank address. Instantiated twice (L1, L2). The IFM path uses a plain counter.
// TESTING
//  1. IFM load: mode=1, size_ifm=5, valid stream -> ifm_we 5 cycles, addr 0..4; done 1 cycle after the 5th write.
//  2. Weight load: L1=34, L2=6, defaults -> word 17 hits l1_we[1] at addr 1; word 33 hits bank1 addr 2;
//     L2 words 4,5 hit banks 0,1 at addr 1; no gap between phases.
//  3. Bubbles: in_valid toggles every other cycle with size_w_l1=4, size_w_l2=0 -> 4 writes, banks 0..3
//     in order, done after the 4th.
//  4. Edges: start mode=2, both sizes 0 -> done the cycle after start. Start with mode=3 -> err_mode=1,
//     stays IDLE, in_ready=0.
//  5. abort after 3 of 10 IFM words -> no further we, no done, busy=0. A new start writes from addr 0.
//  6. With LOAD_ROUTER_CHECKSUM_EN: words 1,2,0xFFFFFFFF -> checksum 2 at done.

Source files
------------

// File: rtl/load_router_pkg.sv
// Shared types for the load data router.
//   load_mode_e    : encoding of the control_load_i input
//   router_state_e : load sequencing FSM states
package load_router_pkg;

    typedef enum logic [1:0] {
        NO_LOAD     = 2'd0,
        LOAD_IFM    = 2'd1,
        LOAD_WEIGHT = 2'd2
    } load_mode_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LD_IFM = 3'd1,
        LD_W1  = 3'd2,
        LD_W2  = 3'd3,
        FIN    = 3'd4
    } router_state_e;

endpackage

// File: rtl/bank_stripe_gen.sv
// Word counter that stripes consecutive words round-robin across NBANKS banks.
// Word k goes to bank (k mod NBANKS) at bank address (k >> log2(NBANKS)).
// we_o and addr_o are registered: an advance in cycle t shows up at t+1.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clear_i    : synchronous counter clear (new load or abort)
//   adv_i      : a word is being written this cycle
//   cnt_o      : words written so far in this phase
//   we_o       : one-hot bank write enable (registered)
//   addr_o     : shared bank word address (registered)
// Requires SIZE_W >= log2(NBANKS) + BANK_AW.
module bank_stripe_gen #(
    parameter int unsigned NBANKS  = 16,
    parameter int unsigned BANK_AW = 16,
    parameter int unsigned SIZE_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              adv_i,
    output logic [SIZE_W-1:0] cnt_o,
    output logic [NBANKS-1:0] we_o,
    output logic [BANK_AW-1:0] addr_o
);

    localparam int unsigned SelW = $clog2(NBANKS);
    localparam logic [SIZE_W-1:0] OneW = {{(SIZE_W-1){1'b0}}, 1'b1};

    logic [SIZE_W-1:0]  cnt_q, cnt_d;
    logic [NBANKS-1:0]  we_q, we_d;
    logic [BANK_AW-1:0] addr_q, addr_d;

    always_comb begin
        cnt_d  = cnt_q;
        we_d   = '0;
        addr_d = addr_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (adv_i) begin
            cnt_d                  = cnt_q + OneW;
            we_d[cnt_q[SelW-1:0]]  = 1'b1;
            addr_d                 = cnt_q[SelW +: BANK_AW];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            we_q   <= '0;
            addr_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            we_q   <= we_d;
            addr_q <= addr_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign we_o   = we_q;
    assign addr_o = addr_q;

endmodule

// File: rtl/load_data_router.sv
// Routes a stream of load words into the IFM buffer or the layer-1/layer-2 weight banks.
// Destination is derived from internal per-phase word counters, not from an address input.
// A weight load runs the L1 phase then the L2 phase; an IFM load runs a single phase.
// Ports:
//   clk, rst_n               : clock, async active-low reset
//   start_i, control_load_i  : start pulse and load mode (0 none, 1 IFM, 2 weights, 3 reserved)
//   size_ifm_i/size_w_l1_i/size_w_l2_i : per-phase word counts, sampled on accepted start
//   abort_i                  : synchronous abort back to IDLE (drops a coincident beat)
//   in_valid_i/in_ready_o/in_data_i    : load word handshake
//   wr_data_o                : registered word broadcast to all banks
//   ifm_we_o/ifm_addr_o      : IFM write enable and word address
//   l1_we_o/l1_addr_o        : one-hot L1 bank enable and shared bank address
//   l2_we_o/l2_addr_o        : one-hot L2 bank enable and shared bank address
//   busy_o, done_o           : load in progress, one-cycle end-of-load pulse
//   err_mode_o               : sticky flag for a start with mode 0 or 3
// Optional feature: define LOAD_ROUTER_CHECKSUM_EN to add checksum_o, the modulo-2^DATA_W sum of
// words accepted since the last start (cleared on start/abort, valid while done_o is high).
module load_data_router
    import load_router_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned L1_BANKS = 16,
    parameter int unsigned L2_BANKS = 4,
    parameter int unsigned BANK_AW  = 16,
    parameter int unsigned SIZE_W   = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic [1:0]          control_load_i,
    input  logic [SIZE_W-1:0]   size_ifm_i,
    input  logic [SIZE_W-1:0]   size_w_l1_i,
    input  logic [SIZE_W-1:0]   size_w_l2_i,
    input  logic                abort_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [DATA_W-1:0]   in_data_i,
    output logic [DATA_W-1:0]   wr_data_o,
    output logic                ifm_we_o,
    output logic [SIZE_W-1:0]   ifm_addr_o,
    output logic [L1_BANKS-1:0] l1_we_o,
    output logic [BANK_AW-1:0]  l1_addr_o,
    output logic [L2_BANKS-1:0] l2_we_o,
    output logic [BANK_AW-1:0]  l2_addr_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_mode_o
`ifdef LOAD_ROUTER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0]   checksum_o
`endif
);

    localparam logic [SIZE_W-1:0] OneW = {{(SIZE_W-1){1'b0}}, 1'b1};

    router_state_e     state_q;
    logic [SIZE_W-1:0] size_ifm_q, size_l1_q, size_l2_q;
    logic              err_q;

    logic [SIZE_W-1:0] ifm_cnt_q, ifm_addr_q;
    logic              ifm_we_q;
    logic [DATA_W-1:0] wr_data_q;

    logic [SIZE_W-1:0] l1_cnt, l2_cnt;
    logic              start_acc, clear, beat;
    logic              ifm_beat, l1_adv, l2_adv;
    logic              ifm_last, l1_last, l2_last;

    assign in_ready_o = (state_q == LD_IFM) || (state_q == LD_W1) || (state_q == LD_W2);
    assign busy_o     = (state_q != IDLE);
    assign done_o     = (state_q == FIN);
    assign err_mode_o = err_q;

    assign start_acc = (state_q == IDLE) && start_i && !abort_i;
    assign clear     = abort_i || start_acc;
    // Abort drops any coincident beat.
    assign beat      = in_valid_i && in_ready_o && !abort_i;
    assign ifm_beat  = beat && (state_q == LD_IFM);
    assign l1_adv    = beat && (state_q == LD_W1);
    assign l2_adv    = beat && (state_q == LD_W2);

    // Phases are only entered with a nonzero size, so size-1 never underflows here.
    assign ifm_last = (ifm_cnt_q == size_ifm_q - OneW);
    assign l1_last  = (l1_cnt == size_l1_q - OneW);
    assign l2_last  = (l2_cnt == size_l2_q - OneW);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            size_ifm_q <= '0;
            size_l1_q  <= '0;
            size_l2_q  <= '0;
            err_q      <= 1'b0;
        end else if (abort_i) begin
            state_q <= IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        size_ifm_q <= size_ifm_i;
                        size_l1_q  <= size_w_l1_i;
                        size_l2_q  <= size_w_l2_i;
                        case (control_load_i)
                            LOAD_IFM: begin
                                err_q   <= 1'b0;
                                state_q <= (size_ifm_i == '0) ? FIN : LD_IFM;
                            end
                            LOAD_WEIGHT: begin
                                err_q   <= 1'b0;
                                // Empty phases are skipped in the same transition.
                                state_q <= (size_w_l1_i != '0) ? LD_W1 :
                                           (size_w_l2_i != '0) ? LD_W2 : FIN;
                            end
                            default: err_q <= 1'b1;
                        endcase
                    end
                end
                LD_IFM: if (ifm_beat && ifm_last) state_q <= FIN;
                LD_W1: begin
                    if (l1_adv && l1_last) state_q <= (size_l2_q == '0) ? FIN : LD_W2;
                end
                LD_W2: if (l2_adv && l2_last) state_q <= FIN;
                FIN:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifm_cnt_q  <= '0;
            ifm_addr_q <= '0;
            ifm_we_q   <= 1'b0;
            wr_data_q  <= '0;
        end else begin
            ifm_we_q <= ifm_beat;
            if (clear) begin
                ifm_cnt_q <= '0;
            end else if (ifm_beat) begin
                ifm_addr_q <= ifm_cnt_q;
                ifm_cnt_q  <= ifm_cnt_q + OneW;
            end
            if (beat) wr_data_q <= in_data_i;
        end
    end

    bank_stripe_gen #(
        .NBANKS (L1_BANKS),
        .BANK_AW(BANK_AW),
        .SIZE_W (SIZE_W)
    ) u_l1_stripe (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear_i(clear),
        .adv_i  (l1_adv),
        .cnt_o  (l1_cnt),
        .we_o   (l1_we_o),
        .addr_o (l1_addr_o)
    );

    bank_stripe_gen #(
        .NBANKS (L2_BANKS),
        .BANK_AW(BANK_AW),
        .SIZE_W (SIZE_W)
    ) u_l2_stripe (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear_i(clear),
        .adv_i  (l2_adv),
        .cnt_o  (l2_cnt),
        .we_o   (l2_we_o),
        .addr_o (l2_addr_o)
    );

    assign wr_data_o  = wr_data_q;
    assign ifm_we_o   = ifm_we_q;
    assign ifm_addr_o = ifm_addr_q;

`ifdef LOAD_ROUTER_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else if (clear) begin
            csum_q <= '0;
        end else if (beat) begin
            csum_q <= csum_q + in_data_i;
        end
    end

    assign checksum_o = csum_q;
`endif

endmodule

// File: tb/tb_load_data_router.sv
module tb_load_data_router;

    localparam int DW  = 32;
    localparam int L1B = 16;
    localparam int L2B = 4;
    localparam int AW  = 16;
    localparam int SW  = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [1:0]     control_load = 2'd0;
    logic [SW-1:0]  size_ifm = '0, size_w_l1 = '0, size_w_l2 = '0;
    logic           abort = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [DW-1:0]  in_data = '0;
    logic [DW-1:0]  wr_data;
    logic           ifm_we;
    logic [SW-1:0]  ifm_addr;
    logic [L1B-1:0] l1_we;
    logic [AW-1:0]  l1_addr;
    logic [L2B-1:0] l2_we;
    logic [AW-1:0]  l2_addr;
    logic           busy, done, err_mode;
`ifdef LOAD_ROUTER_CHECKSUM_EN
    logic [DW-1:0]  checksum;
`endif

    always #5 clk = ~clk;

    load_data_router u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start),
        .control_load_i(control_load),
        .size_ifm_i    (size_ifm),
        .size_w_l1_i   (size_w_l1),
        .size_w_l2_i   (size_w_l2),
        .abort_i       (abort),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .in_data_i     (in_data),
        .wr_data_o     (wr_data),
        .ifm_we_o      (ifm_we),
        .ifm_addr_o    (ifm_addr),
        .l1_we_o       (l1_we),
        .l1_addr_o     (l1_addr),
        .l2_we_o       (l2_we),
        .l2_addr_o     (l2_addr),
        .busy_o        (busy),
        .done_o        (done),
        .err_mode_o    (err_mode)
`ifdef LOAD_ROUTER_CHECKSUM_EN
        ,
        .checksum_o    (checksum)
`endif
    );

    typedef struct {
        logic           ifm;
        logic [L1B-1:0] l1;
        logic [L2B-1:0] l2;
        logic [SW-1:0]  addr;
        logic [DW-1:0]  data;
        logic           done;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] data_q[$];
    int            n_checks = 0;
    int            n_err = 0;

    logic [L1B-1:0] obs_l1_we[256];
    logic [AW-1:0]  obs_l1_addr[256];
    logic [L2B-1:0] obs_l2_we[256];
    logic [AW-1:0]  obs_l2_addr[256];
    int             l1_seen = 0;
    int             l2_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every cycle with a write or done must match the next expected record.
    always @(negedge clk) begin
        logic [SW-1:0] aa;
        logic [DW-1:0] dd;
        exp_t          e;
        if (rst_n && (ifm_we || (|l1_we) || (|l2_we) || done)) begin
            aa = ifm_we ? ifm_addr : (|l1_we) ? SW'(l1_addr) : (|l2_we) ? SW'(l2_addr) : '0;
            dd = (ifm_we || (|l1_we) || (|l2_we)) ? wr_data : '0;
            if (|l1_we && l1_seen < 256) begin
                obs_l1_we[l1_seen]   = l1_we;
                obs_l1_addr[l1_seen] = l1_addr;
                l1_seen++;
            end
            if (|l2_we && l2_seen < 256) begin
                obs_l2_we[l2_seen]   = l2_we;
                obs_l2_addr[l2_seen] = l2_addr;
                l2_seen++;
            end
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_output: ifm_we=%0b l1_we=%0h l2_we=%0h done=%0b required=none",
                         ifm_we, l1_we, l2_we, done);
            end else begin
                e = exp_q.pop_front();
                chk("sb_ifm_we", 64'(ifm_we), 64'(e.ifm));
                chk("sb_l1_we", 64'(l1_we), 64'(e.l1));
                chk("sb_l2_we", 64'(l2_we), 64'(e.l2));
                chk("sb_addr", 64'(aa), 64'(e.addr));
                chk("sb_data", 64'(dd), 64'(e.data));
                chk("sb_done", 64'(done), 64'(e.done));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start(input logic [1:0] mode, input int si, input int s1, input int s2);
        exp_t e;
        @(negedge clk);
        start        = 1'b1;
        control_load = mode;
        size_ifm     = SW'(si);
        size_w_l1    = SW'(s1);
        size_w_l2    = SW'(s2);
        if ((mode == 2'd1 && si == 0) || (mode == 2'd2 && s1 == 0 && s2 == 0)) begin
            e = '{ifm: 1'b0, l1: '0, l2: '0, addr: '0, data: '0, done: 1'b1};
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // Feeds the words of a load; abort_after >= 0 aborts once that many words were sent.
    task automatic stream(input int mode, input int si, input int s1, input int s2,
                          input bit bubble, input int abort_after, input logic [DW-1:0] base);
        int            ph_n[3];
        int            total;
        int            sent = 0;
        int            stalls = 0;
        int            w;
        exp_t          e;
        logic [DW-1:0] d;
        if (mode == 1) begin
            ph_n[0] = si; ph_n[1] = 0; ph_n[2] = 0;
        end else begin
            ph_n[0] = 0; ph_n[1] = s1; ph_n[2] = s2;
        end
        total = ph_n[0] + ph_n[1] + ph_n[2];
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < ph_n[p]; k++) begin
                if (abort_after >= 0 && sent == abort_after) begin
                    abort    = 1'b1;
                    in_valid = 1'b1;
                    in_data  = 32'hDEAD_BEEF;
                    @(negedge clk);
                    abort    = 1'b0;
                    in_valid = 1'b0;
                    return;
                end
                if (bubble && sent > 0) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                end
                d        = (data_q.size() > 0) ? data_q.pop_front() : base + DW'(sent);
                in_valid = 1'b1;
                in_data  = d;
                w = 0;
                while (!in_ready && w < 20) begin
                    @(negedge clk);
                    w++;
                    stalls++;
                end
                if (!in_ready) begin
                    chk("in_ready_timeout", 64'(in_ready), 64'd1);
                    in_valid = 1'b0;
                    return;
                end
                e.ifm  = (p == 0);
                e.l1   = '0;
                e.l2   = '0;
                if (p == 1) e.l1[k % L1B] = 1'b1;
                if (p == 2) e.l2[k % L2B] = 1'b1;
                e.addr = (p == 0) ? SW'(k) : (p == 1) ? SW'(k / L1B) : SW'(k / L2B);
                e.data = d;
                e.done = (sent == total - 1);
                exp_q.push_back(e);
                @(negedge clk);
                sent++;
            end
        end
        in_valid = 1'b0;
        chk("no_stall", 64'(stalls), 64'd0);
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, required=finish");
        $fatal(1);
    end

    initial begin
        int b1, b2;

        // Reset state
        idle(3);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        idle(1);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err_mode), 64'd0);
        chk("rst_we", 64'({ifm_we, l1_we, l2_we}), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        chk("rst_addr", 64'({ifm_addr, l1_addr, l2_addr}), 64'd0);

        // 1. IFM load of 5 words, addr 0..4, done with the last write
        do_start(2'd1, 5, 0, 0);
        chk("ifm_busy", 64'(busy), 64'd1);
        stream(1, 5, 0, 0, 1'b0, -1, 32'h1000_0000);
        drain();
        idle(2);
        chk("ifm_idle_busy", 64'(busy), 64'd0);

        // 2. Weight load L1=34, L2=6, no gap between phases
        b1 = l1_seen;
        b2 = l2_seen;
        do_start(2'd2, 0, 34, 6);
        stream(2, 0, 34, 6, 1'b0, -1, 32'h2000_0000);
        drain();
        chk("w_word17_we", 64'(obs_l1_we[b1 + 17]), 64'h0002);
        chk("w_word17_addr", 64'(obs_l1_addr[b1 + 17]), 64'd1);
        chk("w_word33_we", 64'(obs_l1_we[b1 + 33]), 64'h0002);
        chk("w_word33_addr", 64'(obs_l1_addr[b1 + 33]), 64'd2);
        chk("w_l2word4_we", 64'(obs_l2_we[b2 + 4]), 64'h1);
        chk("w_l2word4_addr", 64'(obs_l2_addr[b2 + 4]), 64'd1);
        chk("w_l2word5_we", 64'(obs_l2_we[b2 + 5]), 64'h2);
        chk("w_l2word5_addr", 64'(obs_l2_addr[b2 + 5]), 64'd1);
        idle(2);

        // 3. Bubbles: L1=4, L2=0
        do_start(2'd2, 0, 4, 0);
        stream(2, 0, 4, 0, 1'b1, -1, 32'h3000_0000);
        drain();
        idle(2);

        // 4. Reserved mode, then weight load with both sizes zero
        do_start(2'd3, 7, 7, 7);
        chk("err_set", 64'(err_mode), 64'd1);
        chk("err_busy", 64'(busy), 64'd0);
        chk("err_in_ready", 64'(in_ready), 64'd0);
        idle(1);
        chk("err_sticky", 64'(err_mode), 64'd1);
        do_start(2'd2, 0, 0, 0);
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_err_cleared", 64'(err_mode), 64'd0);
        idle(1);
        chk("zero_done_pulse", 64'(done), 64'd0);
        chk("zero_busy", 64'(busy), 64'd0);
        drain();

        // 5. Abort after 3 of 10 IFM words, then a fresh load from addr 0
        do_start(2'd1, 10, 0, 0);
        stream(1, 10, 0, 0, 1'b0, 3, 32'h5000_0000);
        idle(3);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        drain();
        do_start(2'd1, 2, 0, 0);
        stream(1, 2, 0, 0, 1'b0, -1, 32'h6000_0000);
        drain();
        idle(2);

`ifdef LOAD_ROUTER_CHECKSUM_EN
        // 6. Checksum of 1 + 2 + 0xFFFFFFFF wraps to 2
        data_q.push_back(32'h1);
        data_q.push_back(32'h2);
        data_q.push_back(32'hFFFF_FFFF);
        do_start(2'd1, 3, 0, 0);
        stream(1, 3, 0, 0, 1'b0, -1, 32'h0);
        chk("csum_done", 64'(done), 64'd1);
        chk("csum_value", 64'(checksum), 64'd2);
        drain();
        idle(2);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
